reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 164 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Brief    : Circular in-order retirement buffer. Entries are allocated at
//            dispatch, marked complete by writeback and retired from the head
//            in program order. An excepting head squashes the whole buffer.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter  int DEPTH  = 16,
    parameter  int AREG_W = 5,
    parameter  int PREG_W = 6,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    // dispatch
    input  logic              dispatch_en,
    input  logic              disp_has_dest,
    input  logic              disp_is_mem,
    input  logic [AREG_W-1:0] disp_areg,
    input  logic [PREG_W-1:0] disp_preg,
    input  logic [PREG_W-1:0] disp_old_preg,
    output logic [TAG_W-1:0]  disp_tag,
    output logic              rob_full,
    output logic              rob_empty,
    output logic [TAG_W:0]    rob_count,
    // writeback
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic              wb_exception,
    // commit
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [AREG_W-1:0] commit_areg,
    output logic [PREG_W-1:0] commit_preg,
    output logic [PREG_W-1:0] commit_old_preg,
    output logic              commit_has_dest,
    output logic              commit_is_mem,
    output logic              flush
);

    localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [TAG_W:0]    head_q, head_d;
    logic [TAG_W:0]    tail_q, tail_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [DEPTH-1:0]  exc_q, exc_d;

    // Payload storage, never reset.
    logic [AREG_W-1:0] areg_q     [DEPTH];
    logic [AREG_W-1:0] areg_d     [DEPTH];
    logic [PREG_W-1:0] preg_q     [DEPTH];
    logic [PREG_W-1:0] preg_d     [DEPTH];
    logic [PREG_W-1:0] old_preg_q [DEPTH];
    logic [PREG_W-1:0] old_preg_d [DEPTH];
    logic [DEPTH-1:0]  has_dest_q, has_dest_d;
    logic [DEPTH-1:0]  is_mem_q, is_mem_d;

    logic [TAG_W-1:0]  head_idx;
    logic [TAG_W-1:0]  tail_idx;
    logic              do_dispatch;
    logic              do_commit;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];

    // Status and head-entry views, all derived from registered state only.
    always_comb begin
        rob_empty       = (head_q == tail_q);
        rob_full        = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
        rob_count       = tail_q - head_q;
        disp_tag        = tail_idx;
        commit_valid    = !rob_empty && done_q[head_idx] && !exc_q[head_idx];
        flush           = !rob_empty && done_q[head_idx] &&  exc_q[head_idx];
        commit_areg     = areg_q[head_idx];
        commit_preg     = preg_q[head_idx];
        commit_old_preg = old_preg_q[head_idx];
        commit_has_dest = has_dest_q[head_idx];
        commit_is_mem   = is_mem_q[head_idx];
        // A flushing cycle swallows any dispatch presented alongside it.
        do_dispatch     = dispatch_en && !rob_full && !flush;
        do_commit       = commit_valid && commit_ready;
    end

    // Next-state for pointers and per-entry status. Dispatch is applied after
    // writeback so that a same-index collision leaves the entry not done.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        done_d  = done_q;
        exc_d   = exc_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            valid_d = '0;
            done_d  = '0;
            exc_d   = '0;
        end else begin
            if (wb_valid && valid_q[wb_tag]) begin
                done_d[wb_tag] = 1'b1;
                exc_d[wb_tag]  = wb_exception;
            end
            if (do_commit) begin
                valid_d[head_idx] = 1'b0;
                head_d            = head_q + PTR_ONE;
            end
            if (do_dispatch) begin
                valid_d[tail_idx] = 1'b1;
                done_d[tail_idx]  = 1'b0;
                exc_d[tail_idx]   = 1'b0;
                tail_d            = tail_q + PTR_ONE;
            end
        end
    end

    // Next-state for payload: capture dispatch fields into the tail slot.
    always_comb begin
        areg_d     = areg_q;
        preg_d     = preg_q;
        old_preg_d = old_preg_q;
        has_dest_d = has_dest_q;
        is_mem_d   = is_mem_q;
        if (do_dispatch) begin
            areg_d[tail_idx]     = disp_areg;
            preg_d[tail_idx]     = disp_preg;
            old_preg_d[tail_idx] = disp_old_preg;
            has_dest_d[tail_idx] = disp_has_dest;
            is_mem_d[tail_idx]   = disp_is_mem;
        end
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
        end
    end

    // Payload registers; contents are meaningless until the slot is dispatched.
    always_ff @(posedge clk) begin
        areg_q     <= areg_d;
        preg_q     <= preg_d;
        old_preg_q <= old_preg_d;
        has_dest_q <= has_dest_d;
        is_mem_q   <= is_mem_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Brief    : Self-checking bench for reorder_buffer. A queue-based model of the
//            in-flight instruction window predicts status and retirement; a
//            negedge monitor compares the DUT against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

    localparam int DEPTH  = 16;
    localparam int AREG_W = 5;
    localparam int PREG_W = 6;
    localparam int TAG_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dispatch_en, disp_has_dest, disp_is_mem;
    logic [AREG_W-1:0] disp_areg;
    logic [PREG_W-1:0] disp_preg, disp_old_preg;
    logic [TAG_W-1:0]  disp_tag;
    logic              rob_full, rob_empty;
    logic [TAG_W:0]    rob_count;
    logic              wb_valid, wb_exception;
    logic [TAG_W-1:0]  wb_tag;
    logic              commit_valid, commit_ready;
    logic [AREG_W-1:0] commit_areg;
    logic [PREG_W-1:0] commit_preg, commit_old_preg;
    logic              commit_has_dest, commit_is_mem, flush;

    reorder_buffer #(.DEPTH(DEPTH), .AREG_W(AREG_W), .PREG_W(PREG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .dispatch_en(dispatch_en), .disp_has_dest(disp_has_dest), .disp_is_mem(disp_is_mem),
        .disp_areg(disp_areg), .disp_preg(disp_preg), .disp_old_preg(disp_old_preg),
        .disp_tag(disp_tag), .rob_full(rob_full), .rob_empty(rob_empty), .rob_count(rob_count),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_exception(wb_exception),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_areg(commit_areg), .commit_preg(commit_preg), .commit_old_preg(commit_old_preg),
        .commit_has_dest(commit_has_dest), .commit_is_mem(commit_is_mem), .flush(flush)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the in-flight window in program order, plus
    // free-running sequence numbers for allocation and retirement.
    typedef struct {
        int areg; int preg; int old_preg;
        bit has_dest; bit is_mem; bit done; bit exc;
    } ent_t;

    ent_t rob[$];
    int   head_seq = 0;
    int   tail_seq = 0;

    // Monitor: compare against the model, then advance the model by one edge.
    always @(negedge clk) begin
        int  n;
        bit  e_cv, e_fl;
        ent_t e;
        if (!rst_n) begin
            chk("rst_empty", rob_empty, 1);
            chk("rst_full", rob_full, 0);
            chk("rst_count", rob_count, 0);
            chk("rst_commit_valid", commit_valid, 0);
            chk("rst_flush", flush, 0);
            chk("rst_disp_tag", disp_tag, 0);
            rob.delete();
            head_seq = 0;
            tail_seq = 0;
        end else begin
            n    = rob.size();
            e_cv = (n > 0) && rob[0].done && !rob[0].exc;
            e_fl = (n > 0) && rob[0].done &&  rob[0].exc;
            chk("empty", rob_empty, int'(n == 0));
            chk("full", rob_full, int'(n == DEPTH));
            chk("count", rob_count, n);
            chk("disp_tag", disp_tag, tail_seq % DEPTH);
            chk("commit_valid", commit_valid, int'(e_cv));
            chk("flush", flush, int'(e_fl));
            if (commit_valid && commit_ready) begin
                if (n == 0) begin
                    chk("commit_on_empty", 1, 0);
                end else begin
                    chk("commit_areg", commit_areg, rob[0].areg);
                    chk("commit_preg", commit_preg, rob[0].preg);
                    chk("commit_old_preg", commit_old_preg, rob[0].old_preg);
                    chk("commit_has_dest", commit_has_dest, int'(rob[0].has_dest));
                    chk("commit_is_mem", commit_is_mem, int'(rob[0].is_mem));
                end
            end
            // advance model across the coming edge
            if (e_fl) begin
                rob.delete();
                head_seq = 0;
                tail_seq = 0;
            end else begin
                if (wb_valid) begin
                    for (int i = 0; i < n; i++) begin
                        if ((head_seq + i) % DEPTH == int'(wb_tag)) begin
                            rob[i].done = 1'b1;
                            rob[i].exc  = wb_exception;
                        end
                    end
                end
                if (e_cv && commit_ready) begin
                    void'(rob.pop_front());
                    head_seq = (head_seq + 1) % (2 * DEPTH);
                end
                if (dispatch_en && n < DEPTH) begin
                    e.areg = int'(disp_areg); e.preg = int'(disp_preg);
                    e.old_preg = int'(disp_old_preg);
                    e.has_dest = disp_has_dest; e.is_mem = disp_is_mem;
                    e.done = 1'b0; e.exc = 1'b0;
                    rob.push_back(e);
                    tail_seq = (tail_seq + 1) % (2 * DEPTH);
                end
            end
        end
    end

    // Present one cycle of stimulus with fresh random payload.
    task automatic step(input bit de, input bit wv, input int wt, input bit we, input bit cr);
        dispatch_en   = de;
        disp_has_dest = 1'($urandom);
        disp_is_mem   = 1'($urandom);
        disp_areg     = AREG_W'($urandom);
        disp_preg     = PREG_W'($urandom);
        disp_old_preg = PREG_W'($urandom);
        wb_valid      = wv;
        wb_tag        = TAG_W'(wt);
        wb_exception  = we;
        commit_ready  = cr;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        dispatch_en = 0; disp_has_dest = 0; disp_is_mem = 0;
        disp_areg = '0; disp_preg = '0; disp_old_preg = '0;
        wb_valid = 0; wb_tag = '0; wb_exception = 0; commit_ready = 0;
        #1;
        chk("por_empty", rob_empty, 1);
        @(posedge clk); #1;
        do_reset();

        // fill to 16, then a rejected 17th dispatch
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_tag", disp_tag, i);
            step(1, 0, 0, 0, 0);
        end
        chk("fill_full", rob_full, 1);
        chk("fill_count", rob_count, 16);
        step(1, 0, 0, 0, 0);
        chk("over_tag", disp_tag, 0);
        chk("over_count", rob_count, 16);

        // out-of-order writeback, in-order retirement
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
        step(0, 1, 2, 0, 1);
        chk("ooo_cv_after2", commit_valid, 0);
        step(0, 1, 1, 0, 1);
        chk("ooo_cv_after1", commit_valid, 0);
        step(0, 1, 0, 0, 1);
        chk("ooo_cv_after0", commit_valid, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        chk("ooo_drained", rob_empty, 1);

        // commit from full with simultaneous dispatch
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("fullcommit_count", rob_count, 15);
        chk("fullcommit_tag", disp_tag, 0);
        step(1, 0, 0, 0, 0);
        chk("refill_count", rob_count, 16);

        // 40 dispatch/writeback/commit triples across two wraps
        do_reset();
        for (int k = 0; k < 40; k++) begin
            step(1, 0, 0, 0, 0);
            step(0, 1, k % DEPTH, 0, 0);
            step(0, 0, 0, 0, 1);
        end
        chk("wrap_empty", rob_empty, 1);
        chk("wrap_tag", disp_tag, 40 % DEPTH);
        step(0, 0, 0, 0, 1);
        chk("wrap_no_cv", commit_valid, 0);

        // exception at head squashes everything
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 1);
        chk("exc_flush", flush, 1);
        chk("exc_cv", commit_valid, 0);
        step(1, 1, 3, 0, 1);
        chk("exc_empty", rob_empty, 1);
        chk("exc_count", rob_count, 0);
        chk("exc_tag", disp_tag, 0);
        chk("exc_flush_low", flush, 0);

        // asynchronous reset between edges
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_empty", rob_empty, 1);
        chk("arst_count", rob_count, 0);
        chk("arst_full", rob_full, 0);
        chk("arst_cv", commit_valid, 0);
        chk("arst_tag", disp_tag, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (rob.size() > 0 && ($urandom % 4) != 0)
                t = (head_seq + int'($urandom % rob.size())) % DEPTH;
            else
                t = int'($urandom % DEPTH);
            step(($urandom % 10) < 6, ($urandom % 3) != 0, t,
                 ($urandom % 24) == 0, ($urandom % 10) < 7);
            if (c % 700 == 699) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
